ysyx_23060077_axi_sram: RTL and testbench

AXI4-Lite slave memory model that terminates the master port of `ysyx_23060077_axi_arbiter` and serves both instruction fetches and load/store traffic of the core. It holds a word-addressed SRAM array behind independent read and write channel state machines, with programmable response latency to expose IFU/LSU stall handling. Sits directly downstream of the arbiter inside the simulation top; it replaces the DPI memory path for timing-accurate runs.

---
 rtl/ysyx_23060077_axi_sram_pkg.sv | 33 +++
 rtl/ysyx_23060077_lfsr8.sv | 26 ++
 rtl/ysyx_23060077_axi_sram.sv | 257 +++++++++++++++++++++++++
 tb/tb_ysyx_23060077_axi_sram.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_axi_sram_pkg.sv
// Shared widths, response codes, FSM encodings and address helper for the AXI4-Lite SRAM model.
package ysyx_23060077_axi_sram_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] span);
        logic [ADDR_W-1:0] off;
        off = addr - base;
        return off < span;
    endfunction

endpackage

// File: rtl/ysyx_23060077_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free running, loads SEED on reset.
// Only exists when YSYX_23060077_SRAM_RAND_DELAY_EN is defined.
`ifdef YSYX_23060077_SRAM_RAND_DELAY_EN
module ysyx_23060077_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] state
);
    logic [7:0] state_q, state_d;

    // Shift left, feedback from taps 8,6,5,4.
    always_comb begin
        state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= SEED;
        else       state_q <= state_d;
    end

    assign state = state_q;
endmodule
`endif

// File: rtl/ysyx_23060077_axi_sram.sv
// AXI4-Lite slave SRAM with independent read/write channels and programmable response latency.
// Define YSYX_23060077_SRAM_RAND_DELAY_EN to replace LATENCY with a per-transaction LFSR delay.
module ysyx_23060077_axi_sram
    import ysyx_23060077_axi_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 65536,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] wait_c;
`ifdef YSYX_23060077_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    ysyx_23060077_lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr)
    );
    assign wait_c = CNT_W'(lfsr[2:0]);
`else
    assign wait_c = CNT_W'(LATENCY);
`endif

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ar_hs_c, rd_sample_c, rd_ok_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [IDX_W-1:0]  rd_idx_c;

    assign ar_hs_c   = s_arvalid && arready_q;
    assign rd_addr_c = ar_hs_c ? s_araddr : r_addr_q;
    assign rd_ok_c   = addr_in_range(rd_addr_c, BASE_ADDR, SPAN);
    assign rd_idx_c  = IDX_W'((rd_addr_c - BASE_ADDR) >> 2);

    // Read FSM next state; a zero wait samples the array on the accepting edge.
    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_cnt_d     = r_cnt_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rd_sample_c = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_c) begin
                    r_addr_d  = s_araddr;
                    arready_d = 1'b0;
                    if (wait_c == '0) rd_sample_c = 1'b1;
                    else begin
                        r_cnt_d   = wait_c - CNT_W'(1);
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) rd_sample_c = 1'b1;
                else               r_cnt_d = r_cnt_q - CNT_W'(1);
            end
            R_RESP: begin
                if (s_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_sample_c) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rdata_d   = rd_ok_c ? mem_q[rd_idx_c] : '0;
            rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read FSM registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs_c, w_hs_c, wr_commit_c, wr_ok_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic [IDX_W-1:0]  wr_idx_c;

    assign aw_hs_c   = s_awvalid && awready_q;
    assign w_hs_c    = s_wvalid && wready_q;
    assign wr_addr_c = aw_hs_c ? s_awaddr : w_addr_q;
    assign wr_data_c = w_hs_c ? s_wdata : w_data_q;
    assign wr_strb_c = w_hs_c ? s_wstrb : w_strb_q;
    assign wr_ok_c   = addr_in_range(wr_addr_c, BASE_ADDR, SPAN);
    assign wr_idx_c  = IDX_W'((wr_addr_c - BASE_ADDR) >> 2);

    // Write FSM next state; AW and W are captured independently, the later one starts the wait.
    always_comb begin
        w_state_d   = w_state_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        w_cnt_d     = w_cnt_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_commit_c = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = !(aw_got_q || aw_hs_c);
                wready_d  = !(w_got_q || w_hs_c);
                if (aw_hs_c) begin
                    aw_got_d = 1'b1;
                    w_addr_d = s_awaddr;
                end
                if (w_hs_c) begin
                    w_got_d  = 1'b1;
                    w_data_d = s_wdata;
                    w_strb_d = s_wstrb;
                end
                if ((aw_got_q || aw_hs_c) && (w_got_q || w_hs_c)) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (wait_c == '0) wr_commit_c = 1'b1;
                    else begin
                        w_cnt_d   = wait_c - CNT_W'(1);
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) wr_commit_c = 1'b1;
                else               w_cnt_d = w_cnt_q - CNT_W'(1);
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_commit_c) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Write FSM registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_cnt_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_cnt_q   <= w_cnt_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane array update; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_commit_c && wr_ok_c) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_c[b]) mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
        end
    end

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_23060077_axi_sram.sv
// Bench for ysyx_23060077_axi_sram: directed scenarios plus randomized traffic against a
// transaction-level model that predicts every output each cycle.
module tb_ysyx_23060077_axi_sram;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 65536;
    localparam int          L     = 2;
    localparam int          TMO   = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
    logic        s_arvalid = 1'b0, s_rready = 1'b0, s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    always #5 clock = ~clock;

    ysyx_23060077_axi_sram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem [int];
    int          cyc = 0;
    bit          live = 1'b0, rst_prev = 1'b0;
    bit          rd_busy = 1'b0, rd_known = 1'b0;
    int          rd_due = 0;
    logic [31:0] rd_addr = '0, rd_data = '0;
    logic [1:0]  rd_resp = '0;
    bit          aw_got = 1'b0, w_got = 1'b0, wr_busy = 1'b0;
    int          wr_due = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_strb = '0;
    bit          e_ar, e_r, e_aw, e_w, e_b;
    logic [31:0] mword;

    // Mid-cycle: compare outputs with the model, then fold in this cycle's handshakes.
    always @(negedge clock) begin
        e_ar = !rst_prev && !rd_busy;
        e_r  = rd_busy && (cyc >= rd_due);
        e_aw = !rst_prev && !wr_busy && !aw_got;
        e_w  = !rst_prev && !wr_busy && !w_got;
        e_b  = wr_busy && (cyc >= wr_due);
        if (live) begin
            chk("arready", 32'(s_arready), 32'(e_ar));
            chk("rvalid",  32'(s_rvalid),  32'(e_r));
            chk("awready", 32'(s_awready), 32'(e_aw));
            chk("wready",  32'(s_wready),  32'(e_w));
            chk("bvalid",  32'(s_bvalid),  32'(e_b));
            if (e_r) begin
                chk("rresp", 32'(s_rresp), 32'(rd_resp));
                if (rd_known) chk("rdata", s_rdata, rd_data);
            end
            if (e_b) chk("bresp", 32'(s_bresp), in_rng(wr_addr) ? 32'd0 : 32'd2);
            if (rst_prev) begin
                chk("rst_rdata", s_rdata, 32'd0);
                chk("rst_rresp", 32'(s_rresp), 32'd0);
                chk("rst_bresp", 32'(s_bresp), 32'd0);
            end
        end
        if (reset) begin
            live = 1'b1; rst_prev = 1'b1;
            rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; wr_busy = 1'b0;
        end else if (live) begin
            rst_prev = 1'b0;
            if (e_ar && s_arvalid) begin
                rd_busy = 1'b1; rd_due = cyc + 1 + L; rd_addr = s_araddr;
            end
            if (rd_busy && cyc == rd_due - 1) begin
                if (in_rng(rd_addr)) begin
                    rd_resp  = 2'b00;
                    rd_known = mdl_mem.exists(widx(rd_addr));
                    if (rd_known) rd_data = mdl_mem[widx(rd_addr)];
                end else begin
                    rd_resp = 2'b10; rd_data = '0; rd_known = 1'b1;
                end
            end
            if (e_r && s_rready) rd_busy = 1'b0;
            if (e_aw && s_awvalid) begin aw_got = 1'b1; wr_addr = s_awaddr; end
            if (e_w && s_wvalid) begin w_got = 1'b1; wr_data = s_wdata; wr_strb = s_wstrb; end
            if (!wr_busy && aw_got && w_got) begin wr_busy = 1'b1; wr_due = cyc + 1 + L; end
            if (wr_busy && cyc == wr_due - 1 && in_rng(wr_addr)) begin
                if (mdl_mem.exists(widx(wr_addr)) || wr_strb == 4'hF) begin
                    mword = mdl_mem.exists(widx(wr_addr)) ? mdl_mem[widx(wr_addr)] : 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) mword[8*b +: 8] = wr_data[8*b +: 8];
                    mdl_mem[widx(wr_addr)] = mword;
                end
            end
            if (e_b && s_bready) begin wr_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
        end
        cyc++;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int n;
        s_araddr = a; s_arvalid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!s_arready && n < TMO) begin @(negedge clock); n++; end
        chk("ar_timeout", 32'(n >= TMO), 32'd0);
        tick();
        s_arvalid = 1'b0;
        s_rready  = (hold == 0);
        n = 0;
        do begin @(negedge clock); n++; end while (!s_rvalid && n < TMO);
        chk("r_timeout", 32'(n >= TMO), 32'd0);
        lat = n; d = s_rdata; r = s_rresp;
        if (hold > 0) begin
            repeat (hold) begin
                tick(); @(negedge clock);
                chk("hold_rvalid", 32'(s_rvalid), 32'd1);
                chk("hold_rdata", s_rdata, d);
                chk("hold_arready", 32'(s_arready), 32'd0);
            end
            tick(); s_rready = 1'b1;
            @(negedge clock);
        end
        tick();
        s_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_at, input int w_at, input int b_hold,
                             output logic [1:0] r, output int lat);
        bit aw_done, w_done;
        int k, n;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        while (!(aw_done && w_done) && k < TMO) begin
            s_awaddr = a; s_wdata = d; s_wstrb = s;
            s_awvalid = !aw_done && (k >= aw_at);
            s_wvalid  = !w_done && (k >= w_at);
            @(negedge clock);
            if (s_awvalid && s_awready) aw_done = 1'b1;
            if (s_wvalid && s_wready) w_done = 1'b1;
            tick();
            k++;
        end
        chk("aw_w_timeout", 32'(k >= TMO), 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = (b_hold == 0);
        n = 0;
        do begin @(negedge clock); n++; end while (!s_bvalid && n < TMO);
        chk("b_timeout", 32'(n >= TMO), 32'd0);
        lat = n; r = s_bresp;
        if (b_hold > 0) begin
            repeat (b_hold) @(posedge clock);
            #1 s_bready = 1'b1;
            @(negedge clock);
        end
        tick();
        s_bready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 8) return BASE + 32'(4 * sel) + 32'h100;
        if (sel == 8) return 32'h8003_FFFC;
        return ($urandom_range(0, 1) == 0) ? 32'h8004_0000 : 32'h7FFF_FFFC;
    endfunction

    task automatic rand_reader(input int count);
        logic [31:0] d; logic [1:0] r; int lat;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            axi_read(pick_addr(), int'($urandom_range(0, 3)), d, r, lat);
        end
    endtask

    task automatic rand_writer(input int count);
        logic [1:0] r; int lat;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            axi_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), r, lat);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_arready", 32'(s_arready), 32'd0);
        chk("reset_awready", 32'(s_awready), 32'd0);
        chk("reset_rvalid",  32'(s_rvalid), 32'd0);
        chk("reset_bvalid",  32'(s_bvalid), 32'd0);
        tick(); reset = 1'b0;
        tick(); @(negedge clock);
        chk("post_reset_arready", 32'(s_arready), 32'd1);
        chk("post_reset_wready",  32'(s_wready), 32'd1);
        tick();

        // Basic write then read.
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r, lat);
        chk("wr1_lat", 32'(lat), 32'd3);
        chk("wr1_bresp", 32'(r), 32'd0);
        axi_read(32'h8000_0010, 0, d, r, lat);
        chk("rd1_lat", 32'(lat), 32'd3);
        chk("rd1_data", d, 32'hDEAD_BEEF);
        chk("rd1_rresp", 32'(r), 32'd0);

        // W leads AW by two cycles with partial strobes.
        axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'hF, 0, 0, 0, r, lat);
        axi_write(32'h8000_0020, 32'h1122_3344, 4'b0101, 2, 0, 0, r, lat);
        chk("wr_strb_lat", 32'(lat), 32'd3);
        axi_read(32'h8000_0020, 0, d, r, lat);
        chk("rd_strb_data", d, 32'hAA22_CC44);

        // Out-of-range accesses and the last in-range word.
        axi_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 0, r, lat);
        axi_read(32'h7FFF_FFFC, 0, d, r, lat);
        chk("oor_rresp", 32'(r), 32'd2);
        chk("oor_rdata", d, 32'd0);
        axi_write(32'h8004_0000, 32'h1234_5678, 4'hF, 0, 0, 0, r, lat);
        chk("oor_bresp", 32'(r), 32'd2);
        axi_read(32'h8000_0000, 0, d, r, lat);
        chk("oor_no_alias", d, 32'h0BAD_F00D);
        axi_write(32'h8003_FFFC, 32'h5A5A_A5A5, 4'hF, 0, 0, 0, r, lat);
        chk("last_bresp", 32'(r), 32'd0);
        axi_read(32'h8003_FFFC, 0, d, r, lat);
        chk("last_rdata", d, 32'h5A5A_A5A5);

        // rready withheld for five cycles.
        axi_read(32'h8000_0010, 5, d, r, lat);
        chk("hold_data", d, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("arready_after_r", 32'(s_arready), 32'd1);
        tick();

        // Same-cycle sample and commit on one word.
        fork
            axi_read(32'h8000_0010, 0, d, r, lat);
            begin
                logic [1:0] wr; int wl;
                axi_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, wr, wl);
            end
        join
        chk("race_old_data", d, 32'hDEAD_BEEF);
        axi_read(32'h8000_0010, 0, d, r, lat);
        chk("race_new_data", d, 32'hCAFE_F00D);

        // Reset while both channels are waiting.
        s_araddr = 32'h8000_0010; s_arvalid = 1'b1;
        s_awaddr = 32'h8000_0010; s_awvalid = 1'b1;
        s_wdata = 32'h5555_5555; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clock);
        chk("rst_test_accept", 32'({s_arready, s_awready, s_wready}), 32'd7);
        tick();
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); @(negedge clock);
        chk("rst_mid_readies", 32'({s_arready, s_awready, s_wready}), 32'd7);
        repeat (8) begin
            tick(); @(negedge clock);
            chk("rst_mid_no_resp", 32'({s_rvalid, s_bvalid}), 32'd0);
        end
        tick();
        axi_read(32'h8000_0010, 0, d, r, lat);
        chk("rst_mid_word", d, 32'hCAFE_F00D);

        // Randomized concurrent traffic over a small address set.
        for (int i = 0; i < 8; i++)
            axi_write(BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, r, lat);
        fork
            rand_reader(50);
            rand_writer(50);
        join
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
